// File: rtl/s2p_parity_rx.sv
// Serial-to-parallel receiver: 8 data bits LSB first plus even parity,
// with stall timeout, parity flag and a one-deep valid/ready output.
module s2p_parity_rx #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_valid,
    input  logic       serial_in,
    output logic [7:0] out_data,
    output logic       out_perr,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [8:0] shift;
    logic [3:0] bit_cnt;
    logic [7:0] gap_cnt;
    logic       done;
    logic       tmo;
    logic       load;
    logic       unused;

    // shift[0] only ever holds a bit that is about to fall off the end
    assign unused = shift[0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (bit_valid)   state_nxt = SHIFT;
            SHIFT: if (done || tmo) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done = 1'b0;
        tmo  = 1'b0;
        if (state == SHIFT) begin
            done = bit_valid && (bit_cnt == 4'd8);
            tmo  = !bit_valid && (gap_cnt == GAP_LAST);
        end
        load = done && (!out_valid || out_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            out_data  <= '0;
            out_perr  <= 1'b0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= tmo;
            overrun   <= done && !load;

            if (bit_valid)
                shift <= {serial_in, shift[8:1]};
            else if (tmo)
                shift <= '0;

            unique case (state)
                IDLE: begin
                    gap_cnt <= '0;
                    if (bit_valid) bit_cnt <= 4'd1;
                end
                SHIFT: begin
                    if (bit_valid) begin
                        gap_cnt <= '0;
                        bit_cnt <= done ? 4'd0 : bit_cnt + 4'd1;
                    end else if (tmo) begin
                        gap_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    gap_cnt <= '0;
                    bit_cnt <= '0;
                end
            endcase

            // the 9th bit is still on serial_in, not yet in shift
            if (load) begin
                out_data  <= shift[8:1];
                out_perr  <= ^{serial_in, shift[8:1]};
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_s2p_parity_rx.sv
// Self-checking bench for s2p_parity_rx: directed scenarios plus
// randomized frames against a queue-based reference.
module tb_s2p_parity_rx;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       bit_valid = 1'b0;
    logic       serial_in = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_perr;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [8:0] acc_q[$];
    logic ready_on_last = 1'b0;

    always #5 clk = ~clk;

    s2p_parity_rx #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .serial_in (serial_in),
        .out_data  (out_data),
        .out_perr  (out_perr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // accepted bytes and pulse counts, sampled at the handshake edge
    always @(posedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) acc_q.push_back({out_perr, out_data});
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
        end
    end

    function automatic logic [8:0] frm(input logic [7:0] d, input logic bad);
        return {(^d) ^ bad, d};
    endfunction

    task automatic send_bits(input logic [8:0] bits, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    @(negedge clk);
                    bit_valid = 1'b0;
                end
            end
            @(negedge clk);
            bit_valid = 1'b1;
            serial_in = bits[i];
            if (i == n - 1 && ready_on_last) out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        if (ready_on_last) out_ready = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycles(1);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        tests++;
        if (out_data !== 8'h00) begin
            fails++; $display("FAIL reset_data: got %h want 00", out_data);
        end
        tests++;
        if (out_perr !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got perr=%b fe=%b ov=%b want 0 0 0",
                     out_perr, frame_err, overrun);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b0;
        send_bits(frm(8'hA5, 1'b0), 9, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_perr !== 1'b0) begin
            fails++;
            $display("FAIL basic_a5: got v=%b d=%h p=%b want 1 a5 0",
                     out_valid, out_data, out_perr);
        end
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            tests++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
                fails++;
                $display("FAIL basic_hold%0d: got v=%b d=%h want 1 a5",
                         i, out_valid, out_data);
            end
        end
        drain();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_accept: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_parity();
        send_bits({1'b0, 8'h01}, 9, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h01 || out_perr !== 1'b1) begin
            fails++;
            $display("FAIL parity_err: got v=%b d=%h p=%b want 1 01 1",
                     out_valid, out_data, out_perr);
        end
        drain();
    endtask

    task automatic test_gaps();
        int fe0;
        fe0 = fe_cnt;
        send_bits(frm(8'h3C, 1'b0), 9, TIMEOUT - 1);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h3C || out_perr !== 1'b0) begin
            fails++;
            $display("FAIL gap_3c: got v=%b d=%h p=%b want 1 3c 0",
                     out_valid, out_data, out_perr);
        end
        drain();
        tests++;
        if (fe_cnt != fe0) begin
            fails++; $display("FAIL gap_no_fe: got %0d want %0d", fe_cnt, fe0);
        end
        send_bits(9'h1FF, 4, 0);
        cycles(TIMEOUT + 4);
        tests++;
        if (fe_cnt != fe0 + 1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL timeout: got fe=%0d v=%b want %0d 0",
                     fe_cnt - fe0, out_valid, 1);
        end
        send_bits(frm(8'hC3, 1'b0), 9, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hC3 || out_perr !== 1'b0) begin
            fails++;
            $display("FAIL after_to_c3: got v=%b d=%h p=%b want 1 c3 0",
                     out_valid, out_data, out_perr);
        end
        drain();
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        out_ready = 1'b0;
        send_bits(frm(8'h11, 1'b0), 9, 0);
        send_bits(frm(8'h22, 1'b0), 9, 0);
        tests++;
        if (overrun !== 1'b1) begin
            fails++; $display("FAIL ovr_pulse: got %b want 1", overrun);
        end
        cycles(2);
        tests++;
        if (ov_cnt != ov0 + 1 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_once: got cnt=%0d now=%b want 1 0",
                     ov_cnt - ov0, overrun);
        end
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h11) begin
            fails++;
            $display("FAIL ovr_hold: got v=%b d=%h want 1 11", out_valid, out_data);
        end
        drain();
        acc_q.delete();
        ov0 = ov_cnt;
        send_bits(frm(8'h11, 1'b0), 9, 0);
        ready_on_last = 1'b1;
        send_bits(frm(8'h22, 1'b0), 9, 0);
        ready_on_last = 1'b0;
        tests++;
        if (overrun !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h22) begin
            fails++;
            $display("FAIL drain_load: got ov=%b v=%b d=%h want 0 1 22",
                     overrun, out_valid, out_data);
        end
        cycles(2);
        tests++;
        if (ov_cnt != ov0 || acc_q.size() != 1 || acc_q[0] !== 9'h011) begin
            fails++;
            $display("FAIL drain_acc: got ov=%0d n=%0d want 0 1",
                     ov_cnt - ov0, acc_q.size());
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int fe0;
        out_ready = 1'b0;
        send_bits(frm(8'h77, 1'b0), 9, 0);
        send_bits(9'h1FF, 5, 0);
        fe0 = fe_cnt;
        @(negedge clk);
        reset = 1'b1;
        cycles(1);
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_perr !== 1'b0 ||
            frame_err !== 1'b0 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: got v=%b d=%h p=%b fe=%b ov=%b want 0 00 0 0 0",
                     out_valid, out_data, out_perr, frame_err, overrun);
        end
        @(negedge clk);
        reset = 1'b0;
        cycles(TIMEOUT + 4);
        tests++;
        if (fe_cnt != fe0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_fe: got fe=%0d v=%b want 0 0",
                     fe_cnt - fe0, out_valid);
        end
        send_bits(frm(8'h5A, 1'b0), 9, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h5A || out_perr !== 1'b0) begin
            fails++;
            $display("FAIL rst_next_5a: got v=%b d=%h p=%b want 1 5a 0",
                     out_valid, out_data, out_perr);
        end
        drain();
    endtask

    task automatic test_random();
        logic [8:0] exp_q[$];
        logic [7:0] d;
        logic       bad;
        int         gap;
        int         fe0;
        int         ov0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        acc_q.delete();
        out_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            d   = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            gap = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 2);
            exp_q.push_back({bad, d});
            send_bits(frm(d, bad), 9, gap);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        cycles(3);
        out_ready = 1'b0;
        tests++;
        if (acc_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL rand_count: got %0d want %0d", acc_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                tests++;
                if (acc_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL rand_byte%0d: got %h want %h", i, acc_q[i], exp_q[i]);
                end
            end
        end
        tests++;
        if (fe_cnt != fe0 || ov_cnt != ov0) begin
            fails++;
            $display("FAIL rand_pulses: got fe=%0d ov=%0d want 0 0",
                     fe_cnt - fe0, ov_cnt - ov0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_gaps();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
